regbank_arbiter: RTL and testbench
==================================

// Module: regbank_arbiter
// PURPOSE
//   Owns a bank of NREGS 32-bit CPU registers and shares its single access port between NREQ
//   requesters (e.g. fetch/decode read path, writeback, debug) with round-robin arbitration.
//   Sequences each access as accept -> execute -> respond; sits between the pipeline stages and the register storage.
// PARAMETERS
//   NREQ   2   number of requesters (2..8)
//   NREGS  16  registers in the bank (<= 2**AW)
//   AW     4   register address width
//   DW     32  data width
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low reset
//   req_valid  in   NREQ     requester i has an access pending
//   req_write  in   NREQ     1 = write, 0 = read (per requester)
//   req_addr   in   NREQ*AW  register index, requester i at [i*AW +: AW]
//   req_wdata  in   NREQ*DW  write data, requester i at [i*DW +: DW]
//   req_lock   in   NREQ     hold grant after this access (only with REG_ARB_LOCK_EN)
//   req_ready  out  NREQ     one-hot; access from i accepted when req_valid[i] & req_ready[i]
//   rsp_valid  out  NREQ     one-hot 1-cycle pulse: access from i completed
//   rsp_rdata  out  DW       read data, valid while rsp_valid is nonzero (0 for writes)
//   busy       out  1        FSM not in IDLE
// BEHAVIOUR
// - Reset (async, active-low): all registers = 0, state = IDLE, rr_ptr = 0;
//   req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0.
// - FSM: IDLE -> EXEC -> RESP -> IDLE. One access per 3 cycles; no pipelining.
//   - IDLE: when any req_valid is set, pick the winner: the first set bit searching from rr_ptr
//     upward with wrap-around. req_ready[winner] = 1 combinationally in this cycle.
//     On the clock edge: latch winner, write flag, addr and wdata; rr_ptr <= (winner+1) mod NREQ; go to EXEC.
//     With no request pending, stay in IDLE.
//   - EXEC: a write updates bank[addr] at the end of this cycle. A read loads rdata_q <= bank[addr].
//     Go to RESP.
//   - RESP: rsp_valid[winner] = 1 for exactly this cycle; rsp_rdata = rdata_q for a read, 0 for a write.
//     Go to IDLE.
// - req_ready is 0 in EXEC and RESP. A requester may hold req_valid high. Its fields must stay
//   stable until accepted; after acceptance they are don't-care.
// - Latency: acceptance edge at cycle t; rsp_valid is high during cycle t+2.
// - A read issued after a write to the same address returns the new data, because the write
//   commits before the next acceptance.
// - Address >= NREGS: the write is dropped, a read returns 0, and rsp_valid still pulses.
// - Simultaneous requests: round-robin only. A requester continuously valid waits at most NREQ-1
//   accesses.
// - reset asserted in EXEC: the write is not committed; the bank clears; no rsp_valid pulse occurs.
// - req_valid dropping before acceptance is legal; nothing is latched.
// CONFIGURATION
//   REG_ARB_LOCK_EN defined:
//   - The req_lock port exists.
//   - If req_lock[winner] = 1 at acceptance, the arbiter sets lock_q and lock_id = winner.
//   - While lock_q = 1, IDLE considers only lock_id and rr_ptr is not advanced.
//   - lock_q clears on an accepted access with req_lock = 0, or on any IDLE cycle where
//     req_valid[lock_id] = 0.
//   - Reset clears lock_q.
//   REG_ARB_LOCK_EN undefined: the req_lock port is absent; arbitration is pure round-robin.
// TESTING
// 1 Reset: bank = 0; req0 reads r5 -> rsp_valid = 01, rsp_rdata = 0, exactly 2 cycles after acceptance.
// 2 req1 writes r3 = 32'hDEADBEEF, then req0 reads r3 -> write ack pulse, then rsp_rdata = DEADBEEF.
// 3 req0 and req1 held valid for 4 accesses from reset -> grant order 0, 1, 0, 1;
//   req_ready is never two-hot.
// 4 NREQ = 2, NREGS = 12: write r14 = 1 -> ack; read r14 -> 0; bank[0..11] unchanged.
// 5 Write r7 = 32'h1234 with reset pulsed low during EXEC -> r7 = 0 afterwards; no rsp_valid pulse.
// 6 LOCK_EN: req0 issues 3 accesses with lock = 1, 1, 0 while req1 is valid -> order 0, 0, 0, 1.

Source files
------------

// File: rtl/regbank_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_arbiter
//
// Purpose:
//   Bank of NREGS DW-bit CPU registers behind a single access port that is
//   shared by NREQ requesters through round-robin arbitration. Each access is
//   sequenced as accept (IDLE) -> execute (EXEC) -> respond (RESP), giving one
//   access per three cycles with no pipelining.
//
// Optional feature macro: REG_ARB_LOCK_EN
//   When defined, the req_lock port exists and a winner that asserts
//   req_lock at acceptance keeps exclusive ownership of the port until it
//   completes an access with req_lock = 0 or drops req_valid while idle.
//
// Handshake:
//   Request side is valid/ready: an access from requester i is accepted on
//   the rising edge where req_valid[i] & req_ready[i] are both high.
//   req_ready is one-hot and only ever asserted in IDLE. The requester's
//   write/addr/wdata fields must stay stable while req_valid is high and
//   not yet accepted; after acceptance they are ignored. There is no
//   back-pressure on the response: rsp_valid[i] is a one-cycle pulse two
//   cycles after acceptance, with rsp_rdata valid in that same cycle.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-low reset
//   req_valid  in   NREQ     requester i has an access pending
//   req_write  in   NREQ     1 = write, 0 = read
//   req_addr   in   NREQ*AW  register index, requester i at [i*AW +: AW]
//   req_wdata  in   NREQ*DW  write data, requester i at [i*DW +: DW]
//   req_lock   in   NREQ     hold grant after this access (REG_ARB_LOCK_EN)
//   req_ready  out  NREQ     one-hot acceptance strobe
//   rsp_valid  out  NREQ     one-hot single-cycle completion pulse
//   rsp_rdata  out  DW       read data during rsp_valid (0 for writes)
//   busy       out  1        FSM not in IDLE
//   dbg_state  out  2        current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module regbank_arbiter #(
  parameter int NREQ  = 2,
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]    req_lock,
`endif
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [DW-1:0]   bank [NREGS];
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   cur_id;
  logic            cur_write;
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wdata;
  logic [DW-1:0]   rdata_q;
  logic            addr_ok;

  logic            found;
  logic [IW-1:0]   win;
  logic            accept;

`ifdef REG_ARB_LOCK_EN
  logic            lock_q;
  logic [IW-1:0]   lock_id;
`endif

  // Indices at or above NREGS have no storage: writes are dropped, reads give 0.
  assign addr_ok = (int'(cur_addr) < NREGS);

  // Winner selection: first pending requester at or after rr_ptr, wrapping.
  // While a lock is held only the lock owner is eligible.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
`ifdef REG_ARB_LOCK_EN
    if (lock_q) begin
      found = req_valid[lock_id];
      win   = lock_id;
    end else begin
`else
    begin
`endif
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          win   = IW'(idx);
        end
      end
    end
  end

  assign accept = (state_q == S_IDLE) && found;

  // FSM next state and outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          state_d        = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[cur_id] = 1'b1;
        rsp_rdata         = rdata_q;
        state_d           = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accepted request fields and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_id    <= '0;
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      cur_id    <= win;
      cur_write <= req_write[win];
      cur_addr  <= req_addr[int'(win)*AW +: AW];
      cur_wdata <= req_wdata[int'(win)*DW +: DW];
`ifdef REG_ARB_LOCK_EN
      // A locked grant does not consume a round-robin turn.
      if (!lock_q) begin
        rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
`else
      rr_ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
    end
  end

`ifdef REG_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q  <= 1'b0;
      lock_id <= '0;
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        lock_q  <= req_lock[win];
        lock_id <= win;
      end else if (lock_q && !req_valid[lock_id]) begin
        // Owner walked away without a final unlocked access.
        lock_q <= 1'b0;
      end
    end
  end
`endif

  // Register storage. Writes commit at the end of EXEC, so a following
  // access (accepted no earlier than the end of RESP) always sees them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        bank[r] <= '0;
      end
    end else if (state_q == S_EXEC && cur_write && addr_ok) begin
      bank[cur_addr] <= cur_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (state_q == S_EXEC) begin
      rdata_q <= (!cur_write && addr_ok) ? bank[cur_addr] : '0;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_arbiter
//
// Bench for regbank_arbiter built with NREQ = 2, NREGS = 12 so that indices
// 12..15 are out of range. Inputs are driven on the falling edge; outputs are
// sampled 1 ns later, away from the rising edge. The reference model is a
// plain array of register values plus a round-robin turn counter.
// ---------------------------------------------------------------------------
module tb_regbank_arbiter;

  localparam int NREQ  = 2;
  localparam int NREGS = 12;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
`ifdef REG_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;
`endif
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               busy;
  logic [1:0]         dbg_state;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [DW-1:0] ref_bank [16];
  int            ref_rr;

  regbank_arbiter #(
    .NREQ (NREQ),
    .NREGS(NREGS),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
`ifdef REG_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return (int'(a) < NREGS) ? ref_bank[a] : '0;
  endfunction

  // Returns the expected winner for a pending mask and advances the turn.
  function automatic int ref_pick(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (ref_rr + k) % NREQ;
      if (mask[c]) begin
        ref_rr = (c + 1) % NREQ;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic apply_reset();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef REG_ARB_LOCK_EN
    req_lock  = '0;
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 16; r++) ref_bank[r] = '0;
    ref_rr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Driver: one access from requester id, with full latency and data checks.
  task automatic do_access(input int id, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input string name);
    logic [DW-1:0]   exp;
    logic [NREQ-1:0] exp_pulse;
    bit              acc;
    @(negedge clk);
    req_valid[id]           = 1'b1;
    req_write[id]           = wr;
    req_addr[id*AW +: AW]   = addr;
    req_wdata[id*DW +: DW]  = wd;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      #1;
      if (req_ready[id]) acc = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL %s accept: req_ready=%b never granted requester %0d", name, req_ready, id);
      req_valid[id] = 1'b0;
      return;
    end
    // Acceptance edge happens now; then scramble the now-don't-care fields.
    @(negedge clk);
    req_valid[id]          = 1'b0;
    req_write[id]          = ~wr;
    req_addr[id*AW +: AW]  = AW'($urandom_range(0, 15));
    req_wdata[id*DW +: DW] = $urandom;
    #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s exec: rsp_valid=%b busy=%b, required rsp_valid=00 busy=1", name, rsp_valid, busy);
    end
    if (wr) begin
      exp = '0;
      if (int'(addr) < NREGS) ref_bank[addr] = wd;
    end else begin
      exp = ref_read(addr);
    end
    exp_pulse = '0;
    exp_pulse[id] = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== exp_pulse || rsp_rdata !== exp) begin
      failures++;
      $display("FAIL %s resp: rsp_valid=%b rsp_rdata=%h, required %b %h", name, rsp_valid, rsp_rdata, exp_pulse, exp);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after: rsp_valid=%b busy=%b, required 00 0", name, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef REG_ARB_LOCK_EN
    req_lock  = '0;
`endif
    reset = 1'b0;
    for (int r = 0; r < 16; r++) ref_bank[r] = '0;
    ref_rr = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rsp=%b rdata=%h busy=%b state=%0d, required all 0",
               req_ready, rsp_valid, rsp_rdata, busy, dbg_state);
    end
    reset = 1'b1;
    do_access(0, 1'b0, 4'd5, '0, "reset_read_r5");
  endtask

  task automatic test_write_then_read();
    do_access(1, 1'b1, 4'd3, 32'hDEADBEEF, "wr_r3");
    do_access(0, 1'b0, 4'd3, '0, "rd_r3");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_access($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 15)), $urandom, "random");
    end
  endtask

  task automatic test_out_of_range();
    do_access(0, 1'b1, 4'd14, 32'h1, "oor_wr_r14");
    do_access(1, 1'b0, 4'd14, '0, "oor_rd_r14");
    for (int r = 0; r < NREGS; r++) begin
      do_access(r % NREQ, 1'b0, AW'(r), '0, "oor_bank_intact");
    end
  endtask

  // Both requesters held valid; grants must alternate from reset.
  task automatic test_round_robin();
    logic [NREQ-1:0] exp_pulse;
    int w;
    int exp_w;
    apply_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {4'd2, 4'd1};
    #1;
    for (int a = 0; a < 4; a++) begin
      int n;
      n = 0;
      while (req_ready === '0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      checks++;
      if ($countones(req_ready) != 1) begin
        failures++;
        $display("FAIL rr_grant%0d: req_ready=%b, required one-hot", a, req_ready);
        break;
      end
      w = (req_ready[1]) ? 1 : 0;
      exp_w = ref_pick(req_valid);
      checks++;
      if (w != exp_w) begin
        failures++;
        $display("FAIL rr_order%0d: granted %0d, required %0d", a, w, exp_w);
      end
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== '0) begin
        failures++;
        $display("FAIL rr_ready_exec%0d: req_ready=%b, required 00", a, req_ready);
      end
      @(negedge clk);
      #1;
      exp_pulse = '0;
      exp_pulse[exp_w] = 1'b1;
      checks++;
      if (rsp_valid !== exp_pulse || rsp_rdata !== '0) begin
        failures++;
        $display("FAIL rr_resp%0d: rsp_valid=%b rdata=%h, required %b 0", a, rsp_valid, rsp_rdata, exp_pulse);
      end
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  // Random contention: random pending masks, losers withdraw unaccepted.
  task automatic test_contention();
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   exp;
    int              exp_w;
    bit              wr [NREQ];
    logic [AW-1:0]   ad [NREQ];
    logic [DW-1:0]   wd [NREQ];
    for (int i = 0; i < 16; i++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
        wr[r] = 1'($urandom_range(0, 1));
        ad[r] = AW'($urandom_range(0, 15));
        wd[r] = $urandom;
        req_write[r]          = wr[r];
        req_addr[r*AW +: AW]  = ad[r];
        req_wdata[r*DW +: DW] = wd[r];
      end
      req_valid = mask;
      #1;
      exp_w = ref_pick(mask);
      exp_ready = '0;
      exp_ready[exp_w] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL contention_grant%0d: mask=%b req_ready=%b, required %b", i, mask, req_ready, exp_ready);
      end
      if (wr[exp_w]) begin
        exp = '0;
        if (int'(ad[exp_w]) < NREGS) ref_bank[ad[exp_w]] = wd[exp_w];
      end else begin
        exp = ref_read(ad[exp_w]);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== exp_ready || rsp_rdata !== exp) begin
        failures++;
        $display("FAIL contention_resp%0d: rsp_valid=%b rdata=%h, required %b %h", i, rsp_valid, rsp_rdata, exp_ready, exp);
      end
    end
    @(negedge clk);
  endtask

  // Reset pulse while a write sits in EXEC: nothing commits, no response.
  task automatic test_reset_exec();
    bit seen;
    do_access(1, 1'b1, 4'd7, 32'hAAAA5555, "pre_wr_r7");
    @(negedge clk);
    req_valid[0]          = 1'b1;
    req_write[0]          = 1'b1;
    req_addr[0 +: AW]     = 4'd7;
    req_wdata[0 +: DW]    = 32'h1234;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_exec_accept: req_ready=%b, required 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;
    for (int r = 0; r < 16; r++) ref_bank[r] = '0;
    ref_rr = 0;
    #2;
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_exec_busy: busy=%b, required 0", busy);
    end
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== '0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_exec_no_pulse: rsp_valid pulsed=1, required 0");
    end
    do_access(1, 1'b0, 4'd7, '0, "rst_exec_rd_r7");
  endtask

`ifdef REG_ARB_LOCK_EN
  task automatic test_lock();
    int exp_order [4];
    int w;
    exp_order = '{0, 0, 0, 1};
    apply_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {4'd1, 4'd2};
    req_lock  = 2'b01;
    #1;
    for (int a = 0; a < 4; a++) begin
      int n;
      n = 0;
      while (req_ready === '0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      w = req_ready[1] ? 1 : (req_ready[0] ? 0 : -1);
      checks++;
      if (w != exp_order[a]) begin
        failures++;
        $display("FAIL lock_order%0d: granted %0d, required %0d", a, w, exp_order[a]);
      end
      @(negedge clk);
      if (a == 1) req_lock[0] = 1'b0;
      if (a == 2) req_valid[0] = 1'b0;
      if (a == 3) req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    req_lock  = '0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    test_reset();
    test_write_then_read();
    test_random();
    test_out_of_range();
    test_round_robin();
    test_contention();
    test_reset_exec();
`ifdef REG_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
